// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: sram-like req/addr_ok/data_ok channel; master issues requests, slave answers
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin inst/data to single memory bridge, one outstanding; ports clk, resetn (sync, active-low), inst/data (slave channels), mem (master channel)
module cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  cpu_mem_arbiter_if.slave  inst,
  cpu_mem_arbiter_if.slave  data,
  cpu_mem_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, wr_q, wr_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic idle, gnt_data, gnt_inst;
  // owner/last: 1 = data, 0 = inst; on conflict the side not granted last wins
  assign idle     = state_q == IDLE;
  assign gnt_data = idle & data.req & (~inst.req | ~last_q);
  assign gnt_inst = idle & inst.req & ~gnt_data;
  assign inst.addr_ok = gnt_inst;
  assign data.addr_ok = gnt_data;
  assign inst.data_ok = state_q == RESP & ~owner_q;
  assign data.data_ok = state_q == RESP & owner_q;
  assign inst.rdata   = rdata_q;
  assign data.rdata   = rdata_q;
  assign mem.req   = state_q == REQ;
  assign mem.wr    = wr_q;
  assign mem.wstrb = wstrb_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (gnt_data | gnt_inst) begin
        state_d = REQ;
        owner_d = gnt_data;
        last_d  = gnt_data;
        wr_d    = gnt_data & data.wr;
        wstrb_d = gnt_data ? data.wstrb : '0;
        addr_d  = gnt_data ? data.addr : inst.addr;
        wdata_d = gnt_data ? data.wdata : '0;
      end
      REQ: if (mem.addr_ok) begin
        state_d = mem.data_ok ? RESP : WAIT;
        rdata_d = mem.data_ok ? mem.rdata : rdata_q;
      end
      WAIT: if (mem.data_ok) begin
        state_d = RESP;
        rdata_d = mem.rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed vectors against hand-computed cycle-by-cycle expectations
module tb_cpu_mem_arbiter;
  logic clk = 0;
  logic resetn = 0;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_b ();
  cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_b ();
  cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_b ();
  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .inst(inst_b), .data(data_b), .mem(mem_b)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask
  initial begin
    inst_b.req = 0; inst_b.wr = 0; inst_b.wstrb = 0; inst_b.addr = 0; inst_b.wdata = 0;
    data_b.req = 0; data_b.wr = 0; data_b.wstrb = 0; data_b.addr = 0; data_b.wdata = 0;
    mem_b.addr_ok = 0; mem_b.data_ok = 0; mem_b.rdata = 0;
    nxt; nxt;
    #1;
    chk("rst mem_req", mem_b.req, 0);
    chk("rst mem_addr", mem_b.addr, 0);
    chk("rst mem_wr", mem_b.wr, 0);
    chk("rst mem_wstrb", mem_b.wstrb, 0);
    chk("rst mem_wdata", mem_b.wdata, 0);
    chk("rst inst_addr_ok", inst_b.addr_ok, 0);
    chk("rst data_addr_ok", data_b.addr_ok, 0);
    chk("rst inst_data_ok", inst_b.data_ok, 0);
    chk("rst data_data_ok", data_b.data_ok, 0);
    chk("rst rdata", data_b.rdata, 0);
    resetn = 1;
    // single fetch, zero-wait bridge
    nxt;
    inst_b.req = 1; inst_b.addr = 32'hBFC00000;
    #1;
    chk("f0 inst_addr_ok", inst_b.addr_ok, 1);
    chk("f0 data_addr_ok", data_b.addr_ok, 0);
    nxt;
    inst_b.req = 0; mem_b.addr_ok = 1;
    #1;
    chk("f1 mem_req", mem_b.req, 1);
    chk("f1 mem_addr", mem_b.addr, 32'hBFC00000);
    chk("f1 mem_wr", mem_b.wr, 0);
    chk("f1 mem_wstrb", mem_b.wstrb, 0);
    chk("f1 inst_addr_ok", inst_b.addr_ok, 0);
    nxt;
    mem_b.addr_ok = 0; mem_b.data_ok = 1; mem_b.rdata = 32'h3C080001;
    #1;
    chk("f2 inst_data_ok", inst_b.data_ok, 0);
    chk("f2 mem_req", mem_b.req, 0);
    nxt;
    mem_b.data_ok = 0;
    #1;
    chk("f3 inst_data_ok", inst_b.data_ok, 1);
    chk("f3 inst_rdata", inst_b.rdata, 32'h3C080001);
    chk("f3 data_data_ok", data_b.data_ok, 0);
    nxt;
    #1;
    chk("f4 inst_data_ok", inst_b.data_ok, 0);
    chk("f4 mem_req", mem_b.req, 0);
    // store with two bridge stall cycles
    data_b.req = 1; data_b.wr = 1; data_b.wstrb = 4'h3; data_b.addr = 32'h00001000; data_b.wdata = 32'h12345678;
    #1;
    chk("s0 data_addr_ok", data_b.addr_ok, 1);
    for (int i = 0; i < 3; i++) begin
      nxt;
      data_b.req = 0; mem_b.addr_ok = (i == 2);
      #1;
      chk($sformatf("s req%0d mem_req", i), mem_b.req, 1);
      chk($sformatf("s req%0d mem_wr", i), mem_b.wr, 1);
      chk($sformatf("s req%0d mem_wstrb", i), mem_b.wstrb, 4'h3);
      chk($sformatf("s req%0d mem_addr", i), mem_b.addr, 32'h00001000);
      chk($sformatf("s req%0d mem_wdata", i), mem_b.wdata, 32'h12345678);
      chk($sformatf("s req%0d data_data_ok", i), data_b.data_ok, 0);
    end
    nxt;
    mem_b.addr_ok = 0; mem_b.data_ok = 1; mem_b.rdata = 32'h0;
    #1;
    chk("s wait data_data_ok", data_b.data_ok, 0);
    chk("s wait mem_req", mem_b.req, 0);
    nxt;
    mem_b.data_ok = 0;
    #1;
    chk("s resp data_data_ok", data_b.data_ok, 1);
    chk("s resp inst_data_ok", inst_b.data_ok, 0);
    data_b.wr = 0; data_b.wstrb = 0; data_b.wdata = 0;
    // conflict from reset: data, inst, data, inst; also same-cycle addr_ok/data_ok
    nxt;
    resetn = 0;
    nxt;
    resetn = 1;
    inst_b.req = 1; inst_b.addr = 32'h100;
    data_b.req = 1; data_b.addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      logic is_data;
      logic [31:0] rd;
      is_data = (k % 2) == 0;
      rd = (k == 0) ? 32'hDEADBEEF : 32'h1000 + k;
      #1;
      chk($sformatf("c%0d data_addr_ok", k), data_b.addr_ok, is_data);
      chk($sformatf("c%0d inst_addr_ok", k), inst_b.addr_ok, !is_data);
      nxt;
      mem_b.addr_ok = 1; mem_b.data_ok = 1; mem_b.rdata = rd;
      #1;
      chk($sformatf("c%0d mem_addr", k), mem_b.addr, is_data ? 32'h200 : 32'h100);
      chk($sformatf("c%0d busy addr_ok", k), {inst_b.addr_ok, data_b.addr_ok}, 0);
      nxt;
      mem_b.addr_ok = 0; mem_b.data_ok = 0;
      #1;
      chk($sformatf("c%0d data_data_ok", k), data_b.data_ok, is_data);
      chk($sformatf("c%0d inst_data_ok", k), inst_b.data_ok, !is_data);
      chk($sformatf("c%0d rdata", k), data_b.rdata, rd);
      nxt;
    end
    inst_b.req = 0; data_b.req = 0;
    // reset while waiting for the response
    data_b.req = 1; data_b.addr = 32'h300;
    #1;
    chk("r0 data_addr_ok", data_b.addr_ok, 1);
    nxt;
    data_b.req = 0; mem_b.addr_ok = 1;
    #1;
    chk("r1 mem_req", mem_b.req, 1);
    nxt;
    mem_b.addr_ok = 0; resetn = 0;
    #1;
    chk("r2 wait mem_req", mem_b.req, 0);
    nxt;
    resetn = 1; mem_b.data_ok = 1; mem_b.rdata = 32'hBAD0BAD0;
    #1;
    chk("r3 mem_req", mem_b.req, 0);
    chk("r3 data_data_ok", data_b.data_ok, 0);
    nxt;
    mem_b.data_ok = 0;
    #1;
    chk("r4 data_data_ok", data_b.data_ok, 0);
    chk("r4 late rdata ignored", data_b.rdata, 0);
    chk("r4 mem_req", mem_b.req, 0);
    inst_b.req = 1; inst_b.addr = 32'h400;
    #1;
    chk("r5 inst_addr_ok", inst_b.addr_ok, 1);
    nxt;
    inst_b.req = 0; mem_b.addr_ok = 1;
    #1;
    chk("r6 mem_addr", mem_b.addr, 32'h400);
    nxt;
    mem_b.addr_ok = 0; mem_b.data_ok = 1; mem_b.rdata = 32'hCAFEF00D;
    nxt;
    mem_b.data_ok = 0;
    #1;
    chk("r8 inst_data_ok", inst_b.data_ok, 1);
    chk("r8 inst_rdata", inst_b.rdata, 32'hCAFEF00D);
    nxt;
    // spurious response in IDLE
    mem_b.data_ok = 1; mem_b.rdata = 32'h55555555;
    nxt;
    mem_b.data_ok = 0;
    #1;
    chk("sp inst_data_ok", inst_b.data_ok, 0);
    chk("sp data_data_ok", data_b.data_ok, 0);
    chk("sp mem_req", mem_b.req, 0);
    chk("sp rdata", inst_b.rdata, 32'hCAFEF00D);
    nxt;
    #1;
    chk("sp2 data_ok", {inst_b.data_ok, data_b.data_ok}, 0);
    chk("sp2 mem_req", mem_b.req, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
